hour_counter: RTL and testbench
===============================

# hour_counter

Two-digit BCD hour counter that sits directly downstream of the minute stage and consumes its carry. It advances once per hour when the minute and second stages are both at their terminal values. It keeps a 24-hour count internally (00–23) and presents either a 24-hour or a 12-hour view with an AM/PM flag. It exposes a level carry at hour 23 for a future day stage and accepts a single-cycle manual-advance request for time setting.

## Interface
- RST_HOUR, 0: reset value of the internal hour, binary 0–23, stored as BCD. Any value above 23 is a configuration error.
- clk  in  1  clock; the time base, one edge per second
- rst_n  in  1  asynchronous active-low reset
- carry_sec  in  1  level; high while seconds = 59
- carry_min  in  1  level; high while minutes = 59
- inc_hour  in  1  single-cycle manual advance request, synchronous to clk
- mode_24  in  1  1 = 24-hour display, 0 = 12-hour display
- hr1  out  4  BCD tens digit of the displayed hour
- hr0  out  4  BCD units digit of the displayed hour
- pm  out  1  12-hour mode: 1 = PM; forced 0 in 24-hour mode
- carry_hour  out  1  level; high while the internal hour = 23 (BCD 2,3)

## Operation
- **State:** internal BCD digits h1 (0–2) and h0 (0–9). These registers are the only state; valid combined range is 00–23.
- **Advance condition:** adv = (carry_min & carry_sec) | inc_hour. If both terms are true in the same cycle, the hour advances exactly once, never twice.
- **Digit stepping:**
  - On adv with h1:h0 = 2:3, load 0:0 (wrap).
  - Otherwise, if h0 = 9, set h0 = 0 and h1 = h1 + 1.
  - Otherwise, h0 = h0 + 1.
  - h0 never exceeds 9; h1 never exceeds 2; the combination 2:4 through 2:9 is unreachable.
- **carry_hour:** combinational, equal to (h1 == 2 && h0 == 3). It is not gated by carry_min or carry_sec; the downstream day stage ANDs all three.
- **24-hour view** (mode_24 = 1): hr1:hr0 = h1:h0, pm = 0.
- **12-hour view** (mode_24 = 0):
  - 00 → 12, pm = 0
  - 01–11 → unchanged, pm = 0
  - 12 → 12, pm = 1
  - 13–19 → 01–07, pm = 1
  - 20–23 → 08–11, pm = 1
- **Display outputs:** hr1, hr0 and pm are combinational functions of h1, h0 and mode_24. Toggling mode_24 never alters the stored count.
- **Input values:** inc_hour and the carries are sampled only at the rising edge of clk. Values between edges are irrelevant.

## Timing
- **Reset:** asserting rst_n low immediately (asynchronously) loads h1:h0 = BCD(RST_HOUR).
  - With the default: hr1 = 0, hr0 = 0 in 24-hour mode; hr1 = 1, hr0 = 2, pm = 0 in 12-hour mode; carry_hour = 0.
- **Reset mid-advance:** reset wins over any pending advance. The first advance after deassertion occurs at the first rising edge where adv = 1 and rst_n = 1.
- **Update latency:** the count updates on the rising clk edge where adv = 1. All outputs reflect the new value in the same cycle, with no additional latency.
- **Natural advance:** because carry_min & carry_sec is high for exactly one second-cycle per hour, natural advance is one step per 3600 edges.
- **Carry timing:** carry_hour rises in the cycle the count becomes 23 and falls in the cycle it wraps to 00.
- **Held inc_hour:** inc_hour held high for N cycles advances N times. Pulse-shaping is the responsibility of the button debouncer upstream.

## Test plan
- **Reset:** RST_HOUR = 0, mode_24 = 1, rst_n low asynchronously, between clock edges → hr1:hr0 = 0:0, pm = 0, carry_hour = 0 immediately.
- **Natural and manual advance:**
  - Hold carry_min = 1, pulse carry_sec for one cycle → 00→01.
  - carry_min = 1 with carry_sec = 0, or carry_sec = 1 with carry_min = 0 → no change.
  - 9 inc_hour pulses from 00 → 09; one more pulse → 10, with h0 rolling 9→0 and h1 1.
- **Wrap:** from 22, inc_hour → 23 with carry_hour = 1; a further inc_hour → 00 with carry_hour = 0.
- **Simultaneous events:** inc_hour, carry_min and carry_sec all high in one cycle at 05 → 06 (single step).
- **12-hour mapping:** sweep all 24 hours with mode_24 = 0 →
  - 00 shows 12/pm 0
  - 11 shows 11/pm 0
  - 12 shows 12/pm 1
  - 13 shows 01/pm 1
  - 23 shows 11/pm 1
  - toggling mode_24 at 17 shows 17 ↔ 05/pm 1 with the internal count unchanged.
- **Reset mid-operation:** at count 14 with adv = 1, assert rst_n low before the edge → count 00; after release, the next adv → 01.

Source files
------------

// File: rtl/hour_counter_if.sv
// Bundles the count-control inputs and the display/carry outputs of the hour stage.
interface hour_counter_if;
    logic       carry_sec;
    logic       carry_min;
    logic       inc_hour;
    logic       mode_24;
    logic [3:0] hr1;
    logic [3:0] hr0;
    logic       pm;
    logic       carry_hour;

    // Master drives the count controls and watches the display.
    modport master (
        output carry_sec, carry_min, inc_hour, mode_24,
        input  hr1, hr0, pm, carry_hour
    );

    // Slave is the hour counter itself.
    modport slave (
        input  carry_sec, carry_min, inc_hour, mode_24,
        output hr1, hr0, pm, carry_hour
    );
endinterface

// File: rtl/hour_counter.sv
// Two-digit BCD hour counter (00-23) with 24-hour and 12-hour views.
// RST_HOUR must be 0..23; larger values are a configuration error.
module hour_counter #(
    parameter int RST_HOUR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    hour_counter_if.slave bus
);

    localparam logic [3:0] RST_H1 = 4'(RST_HOUR / 10);
    localparam logic [3:0] RST_H0 = 4'(RST_HOUR % 10);

    logic [3:0] h1_q;
    logic [3:0] h0_q;
    logic [3:0] h1_d;
    logic [3:0] h0_d;
    logic       adv;

    // Next-count logic: a simultaneous natural and manual advance still steps once.
    always_comb begin
        adv  = (bus.carry_min & bus.carry_sec) | bus.inc_hour;
        h1_d = h1_q;
        h0_d = h0_q;
        if (adv) begin
            if (h1_q == 4'd2 && h0_q == 4'd3) begin
                h1_d = 4'd0;
                h0_d = 4'd0;
            end else if (h0_q == 4'd9) begin
                h1_d = h1_q + 4'd1;
                h0_d = 4'd0;
            end else begin
                h0_d = h0_q + 4'd1;
            end
        end
    end

    // Hour digit registers; reset overrides any advance on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_q <= RST_H1;
            h0_q <= RST_H0;
        end else begin
            h1_q <= h1_d;
            h0_q <= h0_d;
        end
    end

    // Display mapping done directly on BCD digits so no binary conversion is needed.
    always_comb begin
        bus.hr1 = h1_q;
        bus.hr0 = h0_q;
        bus.pm  = 1'b0;
        if (!bus.mode_24) begin
            if (h1_q == 4'd0 && h0_q == 4'd0) begin
                bus.hr1 = 4'd1;
                bus.hr0 = 4'd2;
            end else if (h1_q == 4'd1 && h0_q == 4'd2) begin
                bus.pm  = 1'b1;
            end else if (h1_q == 4'd1 && h0_q >= 4'd3) begin
                bus.hr1 = 4'd0;
                bus.hr0 = h0_q - 4'd2;
                bus.pm  = 1'b1;
            end else if (h1_q == 4'd2 && h0_q <= 4'd1) begin
                bus.hr1 = 4'd0;
                bus.hr0 = h0_q + 4'd8;
                bus.pm  = 1'b1;
            end else if (h1_q == 4'd2) begin
                bus.hr1 = 4'd1;
                bus.hr0 = h0_q - 4'd2;
                bus.pm  = 1'b1;
            end
        end
    end

    // Level carry for the day stage; gating with the minute/second carries happens downstream.
    always_comb begin
        bus.carry_hour = (h1_q == 4'd2) && (h0_q == 4'd3);
    end

endmodule

// File: tb/tb_hour_counter.sv
// Self-checking bench for hour_counter: vector table, directed corner cases, random run.
module tb_hour_counter;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;
    int   model_hour;

    hour_counter_if bus ();

    hour_counter #(.RST_HOUR(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cm;
        logic       cs;
        logic       inc;
        logic       m24;
        logic [3:0] e1;
        logic [3:0] e0;
        logic       epm;
        logic       ecarry;
    } vec_t;

    vec_t vecs[9];

    task automatic check_outputs(input string name, input logic [3:0] e1, input logic [3:0] e0,
                                 input logic epm, input logic ecarry);
        n_total++;
        if (bus.hr1 !== e1 || bus.hr0 !== e0 || bus.pm !== epm || bus.carry_hour !== ecarry) begin
            n_bad++;
            $display("FAIL %s: got hr=%0d%0d pm=%0b carry=%0b, want hr=%0d%0d pm=%0b carry=%0b",
                     name, bus.hr1, bus.hr0, bus.pm, bus.carry_hour, e1, e0, epm, ecarry);
        end
    endtask

    // Reference view computed from an integer hour with plain arithmetic.
    task automatic check_model(input string name);
        int shown;
        logic ep;
        if (bus.mode_24) begin
            shown = model_hour;
            ep    = 1'b0;
        end else begin
            shown = (model_hour % 12 == 0) ? 12 : model_hour % 12;
            ep    = (model_hour >= 12);
        end
        check_outputs(name, 4'(shown / 10), 4'(shown % 10), ep, model_hour == 23);
    endtask

    // Called at a negedge; applies inputs across one rising edge and returns at the next negedge.
    task automatic step(input logic cm, input logic cs, input logic inc, input logic m24);
        bus.carry_min = cm;
        bus.carry_sec = cs;
        bus.inc_hour  = inc;
        bus.mode_24   = m24;
        @(posedge clk);
        if (rst_n && ((cm && cs) || inc)) model_hour = (model_hour + 1) % 24;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_hour = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        model_hour = 0;
        rst_n = 1'b0;
        bus.carry_min = 1'b0;
        bus.carry_sec = 1'b0;
        bus.inc_hour  = 1'b0;
        bus.mode_24   = 1'b1;

        //            cm    cs    inc   m24   e1    e0    pm    carry
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd4, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0};

        @(negedge clk);
        @(negedge clk);
        check_outputs("reset_24h", 4'd0, 4'd0, 1'b0, 1'b0);
        bus.mode_24 = 1'b0;
        #1;
        check_outputs("reset_12h", 4'd1, 4'd2, 1'b0, 1'b0);
        bus.mode_24 = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].cm, vecs[i].cs, vecs[i].inc, vecs[i].m24);
            check_outputs($sformatf("vec%0d", i), vecs[i].e0 === 4'bx ? 4'd0 : vecs[i].e1,
                          vecs[i].e0, vecs[i].epm, vecs[i].ecarry);
        end

        // Asynchronous reset between edges from a nonzero count.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_hour = 0;
        #1;
        check_outputs("async_reset", 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Units roll-over into tens.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        check_outputs("nine_incs", 4'd0, 4'd9, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check_outputs("units_roll", 4'd1, 4'd0, 1'b0, 1'b0);

        // Wrap through 23.
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        check_outputs("at_22", 4'd2, 4'd2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check_outputs("at_23", 4'd2, 4'd3, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check_outputs("wrap_00", 4'd0, 4'd0, 1'b0, 1'b0);

        // Simultaneous natural and manual advance at 05.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check_outputs("simul_adv", 4'd0, 4'd6, 1'b0, 1'b0);

        // 12-hour sweep across all 24 hours.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            check_model($sformatf("sweep12_%0d", i));
            case (i)
                0:  check_outputs("h12_00", 4'd1, 4'd2, 1'b0, 1'b0);
                11: check_outputs("h12_11", 4'd1, 4'd1, 1'b0, 1'b0);
                12: check_outputs("h12_12", 4'd1, 4'd2, 1'b1, 1'b0);
                13: check_outputs("h12_13", 4'd0, 4'd1, 1'b1, 1'b0);
                23: check_outputs("h12_23", 4'd1, 4'd1, 1'b1, 1'b1);
                default: ;
            endcase
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        check_outputs("sweep_back_00", 4'd1, 4'd2, 1'b0, 1'b0);

        // Mode toggle at 17 leaves the count untouched.
        for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        check_outputs("t17_24h", 4'd1, 4'd7, 1'b0, 1'b0);
        bus.mode_24 = 1'b0;
        #1;
        check_outputs("t17_12h", 4'd0, 4'd5, 1'b1, 1'b0);
        bus.mode_24 = 1'b1;
        #1;
        check_outputs("t17_back", 4'd1, 4'd7, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_outputs("t17_hold", 4'd1, 4'd7, 1'b0, 1'b0);

        // Reset with an advance pending at 14.
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        check_outputs("at_14", 4'd1, 4'd4, 1'b0, 1'b0);
        bus.inc_hour = 1'b1;
        #2;
        rst_n = 1'b0;
        model_hour = 0;
        @(posedge clk);
        #1;
        check_outputs("reset_wins", 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check_outputs("after_reset_adv", 4'd0, 4'd1, 1'b0, 1'b0);

        // Random run against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 3) == 0, ($urandom % 2) == 0, ($urandom % 4) == 0, ($urandom % 2) == 0);
            check_model($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
